// File: rtl/sha2_compress_iter.sv
// Iterative SHA-2 compression core (SHA-256 / SHA-512).
// Latches an initial hash, applies one round per accepted (w,k) beat, then
// adds the initial hash back in and holds the digest until downstream takes it.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for an initial hash (start_rdy_o high)
//   RUN   | consuming one (w,k) beat per handshake, one round each
//   FEED  | single cycle: digest = working regs + saved initial hash
//   DONE  | digest presented, held until out_vld_o & out_rdy_i
module sha2_compress_iter #(
    parameter int WORD   = 32,
    parameter int ROUNDS = 64
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr_i,
    input  logic [8*WORD-1:0] in_hash_i,
    input  logic              start_vld_i,
    output logic              start_rdy_o,
    input  logic [WORD-1:0]   w_i,
    input  logic [WORD-1:0]   k_i,
    input  logic              wk_vld_i,
    output logic              wk_rdy_o,
    output logic [8*WORD-1:0] out_hash_o,
    output logic              out_vld_o,
    input  logic              out_rdy_i,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(ROUNDS + 1);

    // Sigma rotation amounts; the SHA-512 set is used only when WORD == 64.
    localparam int R1 = (WORD == 64) ? 14 : 6;
    localparam int R2 = (WORD == 64) ? 18 : 11;
    localparam int R3 = (WORD == 64) ? 41 : 25;
    localparam int R4 = (WORD == 64) ? 28 : 2;
    localparam int R5 = (WORD == 64) ? 34 : 13;
    localparam int R6 = (WORD == 64) ? 39 : 22;

    generate
        if (WORD != 32 && WORD != 64) begin : g_bad_word
            $error("sha2_compress_iter: WORD must be 32 or 64");
        end
        if (ROUNDS < 1 || ROUNDS > 80) begin : g_bad_rounds
            $error("sha2_compress_iter: ROUNDS must be in 1..80");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FEED = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0][WORD-1:0]   work_q, work_d;
    logic [7:0][WORD-1:0]   init_q, init_d;
    logic [7:0][WORD-1:0]   out_hash_q, out_hash_d;
    logic                   out_vld_q, out_vld_d;

    logic [7:0][WORD-1:0]   round_res;
    logic [7:0][WORD-1:0]   feed_sum;
    logic [WORD-1:0]        s0, s1, ch, maj, t1, t2;
    logic                   start_fire, wk_fire, last_beat;

    function automatic logic [WORD-1:0] rotr(input logic [WORD-1:0] x, input int n);
        return (x >> n) | (x << (WORD - n));
    endfunction

    assign start_fire = start_vld_i & start_rdy_o;
    assign wk_fire    = wk_vld_i & wk_rdy_o;
    assign last_beat  = wk_fire && (cnt_q == CNT_W'(ROUNDS - 1));

    // One SHA-2 round on the working registers (a = word 0 ... h = word 7).
    assign s1  = rotr(work_q[4], R1) ^ rotr(work_q[4], R2) ^ rotr(work_q[4], R3);
    assign ch  = (work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6]);
    assign s0  = rotr(work_q[0], R4) ^ rotr(work_q[0], R5) ^ rotr(work_q[0], R6);
    assign maj = (work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]);
    assign t1  = work_q[7] + s1 + ch + k_i + w_i;
    assign t2  = s0 + maj;

    assign round_res = {work_q[6], work_q[5], work_q[4], work_q[3] + t1,
                        work_q[2], work_q[1], work_q[0], t1 + t2};

    // Feed-forward sum of working words and saved initial hash.
    always_comb begin
        feed_sum = '0;
        for (int i = 0; i < 8; i++) begin
            feed_sum[i] = work_q[i] + init_q[i];
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; clr overrides every transition.
    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start_fire) state_d = S_RUN;
                S_RUN:   if (last_beat) state_d = S_FEED;
                S_FEED:  state_d = S_DONE;
                S_DONE:  if (out_vld_q && out_rdy_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs (handshake readies and busy).
    always_comb begin
        start_rdy_o = (state_q == S_IDLE);
        wk_rdy_o    = (state_q == S_RUN);
        busy_o      = (state_q != S_IDLE);
    end

    // Datapath next-state: latch, round, feed-forward, output handshake.
    always_comb begin
        cnt_d      = cnt_q;
        work_d     = work_q;
        init_d     = init_q;
        out_hash_d = out_hash_q;
        out_vld_d  = out_vld_q;
        if (clr_i) begin
            cnt_d     = '0;
            out_vld_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_fire) begin
                        work_d = in_hash_i;
                        init_d = in_hash_i;
                        cnt_d  = '0;
                    end
                end
                S_RUN: begin
                    if (wk_fire) begin
                        work_d = round_res;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
                S_FEED: begin
                    out_hash_d = feed_sum;
                    out_vld_d  = 1'b1;
                end
                S_DONE: begin
                    if (out_rdy_i) out_vld_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q      <= '0;
            work_q     <= '0;
            init_q     <= '0;
            out_hash_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            init_q     <= init_d;
            out_hash_q <= out_hash_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign out_hash_o = out_hash_q;
    assign out_vld_o  = out_vld_q;

endmodule

// File: tb/tb_sha2_compress_iter.sv
// Bench for sha2_compress_iter: SHA-256 core with scoreboard/monitor,
// plus a SHA-512 instance and a single-round instance.
module tb_sha2_compress_iter;

    typedef logic [63:0] w8_t [8];
    typedef logic [63:0] wa_t [80];
    typedef struct {
        logic [255:0] dig;
        int           hold;
    } exp_t;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // SHA-256 instance
    logic         clr, start_vld, start_rdy, wk_vld, wk_rdy, out_vld, out_rdy, busy;
    logic [255:0] in_hash, out_hash;
    logic [31:0]  w, k;

    // SHA-512 instance
    logic         b_start_vld, b_start_rdy, b_wk_vld, b_wk_rdy, b_out_vld, b_busy;
    logic [511:0] b_in_hash, b_out_hash;
    logic [63:0]  b_w, b_k;

    // single-round instance
    logic         c_start_vld, c_start_rdy, c_wk_vld, c_wk_rdy, c_out_vld, c_busy;
    logic [255:0] c_in_hash, c_out_hash;
    logic [31:0]  c_w, c_k;

    logic clr_off = 1'b0;
    logic rdy_on  = 1'b1;

    sha2_compress_iter #(.WORD(32), .ROUNDS(64)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr),
        .in_hash_i(in_hash), .start_vld_i(start_vld), .start_rdy_o(start_rdy),
        .w_i(w), .k_i(k), .wk_vld_i(wk_vld), .wk_rdy_o(wk_rdy),
        .out_hash_o(out_hash), .out_vld_o(out_vld), .out_rdy_i(out_rdy), .busy_o(busy));

    sha2_compress_iter #(.WORD(64), .ROUNDS(80)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr_off),
        .in_hash_i(b_in_hash), .start_vld_i(b_start_vld), .start_rdy_o(b_start_rdy),
        .w_i(b_w), .k_i(b_k), .wk_vld_i(b_wk_vld), .wk_rdy_o(b_wk_rdy),
        .out_hash_o(b_out_hash), .out_vld_o(b_out_vld), .out_rdy_i(rdy_on), .busy_o(b_busy));

    sha2_compress_iter #(.WORD(32), .ROUNDS(1)) u_c (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr_off),
        .in_hash_i(c_in_hash), .start_vld_i(c_start_vld), .start_rdy_o(c_start_rdy),
        .w_i(c_w), .k_i(c_k), .wk_vld_i(c_wk_vld), .wk_rdy_o(c_wk_rdy),
        .out_hash_o(c_out_hash), .out_vld_o(c_out_vld), .out_rdy_i(rdy_on), .busy_o(c_busy));

    logic [31:0] K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [255:0] ABC_DIG =
        256'hf20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf;
    localparam logic [255:0] ONE_ROUND_DIG =
        256'h00000000_00000000_00000000_00000003_00000000_00000000_00000000_00000003;

    exp_t         sb_q[$];
    logic [511:0] b_q[$];
    logic [255:0] c_q[$];
    int           hold_req = 0;
    logic [255:0] last_digest = '0;

    // ---------------- reference model ----------------
    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int wd);
        logic [63:0] m = (wd == 64) ? 64'hffffffff_ffffffff : 64'h00000000_ffffffff;
        return ((x >> n) | (x << (wd - n))) & m;
    endfunction

    function automatic w8_t model(input int wd, input int rounds, input w8_t iv,
                                  input wa_t wv, input wa_t kv);
        w8_t v;
        logic [63:0] m = (wd == 64) ? 64'hffffffff_ffffffff : 64'h00000000_ffffffff;
        int r1 = (wd == 64) ? 14 : 6,  r2 = (wd == 64) ? 18 : 11, r3 = (wd == 64) ? 41 : 25;
        int r4 = (wd == 64) ? 28 : 2,  r5 = (wd == 64) ? 34 : 13, r6 = (wd == 64) ? 39 : 22;
        logic [63:0] bs1, bs0, chv, mj, t1, t2;
        v = iv;
        for (int r = 0; r < rounds; r++) begin
            bs1 = rotr(v[4], r1, wd) ^ rotr(v[4], r2, wd) ^ rotr(v[4], r3, wd);
            chv = ((v[4] & v[5]) ^ (~v[4] & v[6])) & m;
            bs0 = rotr(v[0], r4, wd) ^ rotr(v[0], r5, wd) ^ rotr(v[0], r6, wd);
            mj  = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t1  = (v[7] + bs1 + chv + kv[r] + wv[r]) & m;
            t2  = (bs0 + mj) & m;
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = (v[4] + t1) & m;
            v[0] = (t1 + t2) & m;
        end
        for (int j = 0; j < 8; j++) v[j] = (v[j] + iv[j]) & m;
        return v;
    endfunction

    function automatic logic [255:0] pack32(input w8_t v);
        logic [255:0] p;
        for (int i = 0; i < 8; i++) p[i*32 +: 32] = v[i][31:0];
        return p;
    endfunction

    function automatic logic [511:0] pack64(input w8_t v);
        logic [511:0] p;
        for (int i = 0; i < 8; i++) p[i*64 +: 64] = v[i];
        return p;
    endfunction

    function automatic logic [63:0] sig0(input logic [63:0] x);
        return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3);
    endfunction

    function automatic logic [63:0] sig1(input logic [63:0] x);
        return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
    endfunction

    function automatic wa_t abc_sched();
        wa_t sv;
        for (int i = 0; i < 80; i++) sv[i] = '0;
        sv[0]  = 64'h61626380;
        sv[15] = 64'h00000018;
        for (int t = 16; t < 64; t++)
            sv[t] = (sig1(sv[t-2]) + sv[t-7] + sig0(sv[t-15]) + sv[t-16]) & 64'h00000000_ffffffff;
        return sv;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=no_event_or_in_time", name);
    endtask

    // ---------------- downstream ready with programmable backpressure ----------------
    int bp_cnt = 0;
    initial begin
        out_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (out_vld && rst_n) begin
                if (bp_cnt < hold_req) begin
                    out_rdy = 1'b0;
                    bp_cnt++;
                end else begin
                    out_rdy = 1'b1;
                end
            end else begin
                out_rdy = 1'b0;
                bp_cnt  = 0;
            end
        end
    end

    // ---------------- monitors ----------------
    logic [255:0] held;
    int           vld_cycles = 0;
    bit           in_done = 0, chk_after = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            in_done   = 0;
            chk_after = 0;
        end else if (out_vld) begin
            if (!in_done) begin
                in_done    = 1;
                held       = out_hash;
                vld_cycles = 0;
            end else begin
                chk("hold_stable", 512'(out_hash), 512'(held));
            end
            vld_cycles++;
            if (out_rdy) begin
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_digest");
                end else begin
                    e = sb_q.pop_front();
                    chk("digest", 512'(out_hash), 512'(e.dig));
                    chk("vld_cycles", 512'(vld_cycles), 512'(e.hold + 1));
                end
                in_done   = 0;
                chk_after = 1;
            end
        end else if (chk_after) begin
            chk("start_rdy_after_hs", 512'(start_rdy), 512'(1));
            chk("busy_after_hs", 512'(busy), 512'(0));
            chk_after = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_vld) begin
            if (b_q.size() == 0) fail_now("b_unexpected_digest");
            else chk("b_digest", b_out_hash, b_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && c_out_vld) begin
            if (c_q.size() == 0) fail_now("c_unexpected_digest");
            else chk("c_digest", 512'(c_out_hash), 512'(c_q.pop_front()));
        end
    end

    // ---------------- stimulus ----------------
    wa_t kw256;

    // stop_at < 0: full block; otherwise stop after stop_at beats and abort
    // with clr (use_rst=0) or with an asynchronous reset (use_rst=1).
    task automatic run_a(input w8_t iv, input wa_t wv, input logic [255:0] expd,
                         input int gap_pct, input int hold, input int stop_at, input bit use_rst);
        int n = 0;
        int beats = (stop_at < 0) ? 64 : stop_at;
        wk_vld = 1'b0;
        while (!start_rdy && n < 400) begin @(posedge clk); #1; n++; end
        if (!start_rdy) begin
            fail_now("start_rdy_wait");
            return;
        end
        if (stop_at < 0) begin
            sb_q.push_back('{expd, hold});
            hold_req = hold;
        end
        in_hash   = pack32(iv);
        start_vld = 1'b1;
        @(posedge clk); #1;
        start_vld = 1'b0;
        chk("busy_in_run", 512'(busy), 512'(1));
        for (int r = 0; r < beats; r++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                wk_vld = 1'b0;
                w      = $urandom;
                @(posedge clk); #1;
            end
            wk_vld = 1'b1;
            w      = wv[r][31:0];
            k      = K256[r];
            @(posedge clk); #1;
        end
        wk_vld = 1'b0;
        if (stop_at < 0) begin
            chk("lat_feed_cycle", 512'(out_vld), 512'(0));
            @(posedge clk); #1;
            chk("lat_vld_t_plus_2", 512'(out_vld), 512'(1));
            last_digest = expd;
        end else if (!use_rst) begin
            clr       = 1'b1;
            start_vld = 1'b1;
            wk_vld    = 1'b1;
            in_hash   = {8{$urandom}};
            @(posedge clk); #1;
            clr       = 1'b0;
            start_vld = 1'b0;
            wk_vld    = 1'b0;
            chk("clr_busy", 512'(busy), 512'(0));
            chk("clr_start_rdy", 512'(start_rdy), 512'(1));
            chk("clr_out_vld", 512'(out_vld), 512'(0));
            chk("clr_out_hash_kept", 512'(out_hash), 512'(last_digest));
            @(posedge clk); #1;
            chk("clr_start_ignored", 512'(busy), 512'(0));
        end else begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_out_vld", 512'(out_vld), 512'(0));
            chk("rst_out_hash", 512'(out_hash), 512'(0));
            chk("rst_busy", 512'(busy), 512'(0));
            #3 rst_n = 1'b1;
            @(posedge clk); #1;
            chk("rst_start_rdy", 512'(start_rdy), 512'(1));
            last_digest = '0;
        end
    endtask

    task automatic run_b();
        w8_t iv;
        wa_t wv, kv;
        for (int i = 0; i < 8; i++) iv[i] = {$urandom, $urandom};
        for (int r = 0; r < 80; r++) begin
            wv[r] = {$urandom, $urandom};
            kv[r] = {$urandom, $urandom};
        end
        chk("b_start_rdy", 512'(b_start_rdy), 512'(1));
        b_q.push_back(pack64(model(64, 80, iv, wv, kv)));
        b_in_hash   = pack64(iv);
        b_start_vld = 1'b1;
        @(posedge clk); #1;
        b_start_vld = 1'b0;
        for (int r = 0; r < 80; r++) begin
            b_wk_vld = 1'b1;
            b_w      = wv[r];
            b_k      = kv[r];
            @(posedge clk); #1;
        end
        b_wk_vld = 1'b0;
        chk("b_lat_feed_cycle", 512'(b_out_vld), 512'(0));
        @(posedge clk); #1;
        chk("b_lat_vld", 512'(b_out_vld), 512'(1));
        @(posedge clk); #1;
    endtask

    task automatic run_c(input w8_t iv, input logic [31:0] wi, input logic [31:0] ki,
                         input logic [255:0] expd);
        chk("c_start_rdy", 512'(c_start_rdy), 512'(1));
        c_q.push_back(expd);
        c_in_hash   = pack32(iv);
        c_start_vld = 1'b1;
        @(posedge clk); #1;
        c_start_vld = 1'b0;
        c_wk_vld    = 1'b1;
        c_w         = wi;
        c_k         = ki;
        @(posedge clk); #1;
        c_wk_vld = 1'b0;
        chk("c_lat_feed_cycle", 512'(c_out_vld), 512'(0));
        @(posedge clk); #1;
        chk("c_lat_vld", 512'(c_out_vld), 512'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        w8_t iv_abc, iv_r, zero8;
        wa_t w_abc, w_r, k_r;
        int  n;

        for (int i = 0; i < 80; i++) kw256[i] = (i < 64) ? 64'(K256[i]) : 64'h0;
        iv_abc = '{64'h6a09e667, 64'hbb67ae85, 64'h3c6ef372, 64'ha54ff53a,
                   64'h510e527f, 64'h9b05688c, 64'h1f83d9ab, 64'h5be0cd19};
        for (int i = 0; i < 8; i++) zero8[i] = '0;
        w_abc = abc_sched();

        rst_n = 1'b0; clr = 1'b0; start_vld = 1'b0; wk_vld = 1'b0;
        in_hash = '0; w = '0; k = '0;
        b_start_vld = 1'b0; b_wk_vld = 1'b0; b_in_hash = '0; b_w = '0; b_k = '0;
        c_start_vld = 1'b0; c_wk_vld = 1'b0; c_in_hash = '0; c_w = '0; c_k = '0;
        #12;
        chk("reset_out_vld", 512'(out_vld), 512'(0));
        chk("reset_out_hash", 512'(out_hash), 512'(0));
        chk("reset_busy", 512'(busy), 512'(0));
        chk("reset_start_rdy", 512'(start_rdy), 512'(1));
        chk("reset_wk_rdy", 512'(wk_rdy), 512'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // known-answer block, no gaps, immediate ready
        run_a(iv_abc, w_abc, ABC_DIG, 0, 0, -1, 0);
        // same block with random beat gaps and 5 cycles of backpressure
        run_a(iv_abc, w_abc, ABC_DIG, 35, 5, -1, 0);
        // random blocks against the model
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) iv_r[i] = 64'($urandom);
            for (int r = 0; r < 80; r++) w_r[r] = (r < 64) ? 64'($urandom) : 64'h0;
            run_a(iv_r, w_r, pack32(model(32, 64, iv_r, w_r, kw256)), 20,
                  int'($urandom_range(3)), -1, 0);
        end
        // abort with clr after 30 beats, then a full block
        run_a(iv_abc, w_abc, '0, 0, 0, 30, 0);
        run_a(iv_abc, w_abc, ABC_DIG, 0, 0, -1, 0);
        // asynchronous reset after 10 beats, then a full block
        run_a(iv_abc, w_abc, '0, 0, 0, 10, 1);
        run_a(iv_abc, w_abc, ABC_DIG, 10, 2, -1, 0);

        n = 0;
        while (sb_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        chk("sb_drained", 512'(sb_q.size()), 512'(0));

        // SHA-512 instance
        run_b();
        run_b();

        // single-round instance: directed then random
        begin
            wa_t w1, k1;
            for (int r = 0; r < 80; r++) begin w1[r] = '0; k1[r] = '0; end
            run_c(zero8, 32'd1, 32'd2, ONE_ROUND_DIG);
            for (int i = 0; i < 8; i++) iv_r[i] = 64'($urandom);
            w1[0] = 64'($urandom);
            k1[0] = 64'($urandom);
            run_c(iv_r, w1[0][31:0], k1[0][31:0], pack32(model(32, 1, iv_r, w1, k1)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("b_q_drained", 512'(b_q.size()), 512'(0));
        chk("c_q_drained", 512'(c_q.size()), 512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
